icache: RTL and testbench

Direct-mapped, word-per-block instruction cache between the pipelined datapath's instruction port and the memory controller. Hits return the instruction combinationally in the request cycle, so fetch advances every cycle on a hit. Misses issue a single-word read to memory, fill the frame, and replay the lookup as a hit.

---
 rtl/icache.sv | 89 ++++++++
 tb/tb_icache.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits are combinational
// in the request cycle, and a miss performs a single-word fill before the lookup is replayed.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] miss_cnt
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]      state;
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];
    logic [29:0]     miss_addr;

    logic [IDX-1:0]  req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDX-1:0]  fill_idx;
    logic            hit;
    logic            fill_done;
    logic            unused_byte_bits;

    assign req_idx          = imemaddr[IDX+1:2];
    assign req_tag          = imemaddr[31:IDX+2];
    assign fill_idx         = miss_addr[IDX-1:0];
    assign unused_byte_bits = ^imemaddr[1:0];

    assign hit       = (state == IDLE) && imemREN && valid[req_idx]
                       && (tag_mem[req_idx] == req_tag);
    assign fill_done = (state == FILL) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data_mem[req_idx] : 32'd0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ? {miss_addr, 2'b00} : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, whatever the block order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
            miss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_addr <= imemaddr[31:2];
                        miss_cnt  <= miss_cnt + 32'd1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the tag and data arrays are left unreset, since the valid bits alone
    // gate their use. This lets them map onto plain RAM without reset logic.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= miss_addr[29:IDX];
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a frame-level reference model is compared every
// cycle, and directed scenarios pin the model with hand-computed literals.
module tb_icache;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'd0;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    icache #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .miss_cnt (miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents. Word 0 holds the first instruction, and every other word gets a distinct pattern.
    function automatic logic [31:0] mem_data(input logic [29:0] wa);
        if (wa == 30'd0) return 32'h3C01_0001;
        return {wa[15:0], ~wa[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory responder: holds iwait high for mem_latency cycles of each read.
    int mem_latency = 0;
    int wait_cnt    = 0;
    always @(posedge CLK) begin
        #2;
        if (iREN) begin
            if (wait_cnt < mem_latency) begin
                iwait = 1'b1;
                iload = 32'd0;
                wait_cnt++;
            end else begin
                iwait = 1'b0;
                iload = mem_data(iaddr[31:2]);
            end
        end else begin
            wait_cnt = 0;
            iwait    = 1'b1;
            iload    = 32'd0;
        end
    end

    // Reference model: each frame remembers which full word address it holds.
    bit          m_fill = 1'b0;
    bit          m_valid [SETS];
    logic [29:0] m_wa    [SETS];
    logic [29:0] m_miss  = '0;
    logic [31:0] m_cnt   = '0;

    function automatic bit model_hit();
        logic [29:0] wa;
        wa = imemaddr[31:2];
        return !m_fill && imemREN && m_valid[wa % SETS] && (m_wa[wa % SETS] == wa);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_fill = 1'b0;
            m_miss = '0;
            m_cnt  = '0;
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        end else if (!m_fill) begin
            if (imemREN && !model_hit()) begin
                m_miss = imemaddr[31:2];
                m_cnt  = m_cnt + 32'd1;
                m_fill = 1'b1;
            end
        end else if (!iwait) begin
            m_valid[m_miss % SETS] = 1'b1;
            m_wa[m_miss % SETS]    = m_miss;
            m_fill                 = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            bit h;
            h = model_hit();
            check("model_ihit", {31'd0, ihit}, {31'd0, h});
            check("model_imemload", imemload, h ? mem_data(imemaddr[31:2]) : 32'd0);
            check("model_iREN", {31'd0, iREN}, {31'd0, m_fill});
            check("model_iaddr", iaddr, m_fill ? {m_miss, 2'b00} : 32'd0);
            check("model_miss_cnt", miss_cnt, m_cnt);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Runs from just after an edge until a hit is seen at a falling edge and counts the FILL cycles.
    task automatic run_until_hit(input int max_cycles, output int fills);
        fills = 0;
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge CLK);
            if (ihit) return;
            if (iREN) fills++;
            next_cycle();
        end
        check("hit_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
    } req_t;

    initial begin
        int   fills;
        int   n;
        req_t sweep [6];
        logic [31:0] idle_addrs [3];

        sweep[0] = '{32'h0000_0044, 1};
        sweep[1] = '{32'h0000_0004, 0};
        sweep[2] = '{32'hFFFF_FFFC, 2};
        sweep[3] = '{32'h0000_003C, 0};
        sweep[4] = '{32'h0000_007C, 1};
        sweep[5] = '{32'h0000_007E, 0};
        idle_addrs[0] = 32'h0000_0000;
        idle_addrs[1] = 32'h0000_0010;
        idle_addrs[2] = 32'h0000_0999;

        // Reset, then the first read with two wait cycles.
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; mem_latency = 2;
        #2;
        check("reset_ihit", {31'd0, ihit}, 32'd0);
        check("reset_iREN", {31'd0, iREN}, 32'd0);
        check("reset_iaddr", iaddr, 32'd0);
        check("reset_imemload", imemload, 32'd0);
        check("reset_miss_cnt", miss_cnt, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("first_req_ihit", {31'd0, ihit}, 32'd0);
        next_cycle();
        run_until_hit(20, fills);
        check("first_fill_cycles", fills, 32'd3);
        check("first_load", imemload, 32'h3C01_0001);
        check("first_miss_cnt", miss_cnt, 32'd1);

        // Repeat hit, then a cold neighbour.
        next_cycle();
        @(negedge CLK);
        check("repeat_ihit", {31'd0, ihit}, 32'd1);
        check("repeat_iREN", {31'd0, iREN}, 32'd0);
        next_cycle();
        imemaddr = 32'h4; mem_latency = 0;
        run_until_hit(20, fills);
        check("cold4_fill_cycles", fills, 32'd1);
        check("cold4_miss_cnt", miss_cnt, 32'd2);

        // Conflict eviction on index 0.
        next_cycle();
        imemaddr = 32'h40; mem_latency = 1;
        run_until_hit(20, fills);
        check("conflict_B_fills", fills, 32'd2);
        check("conflict_B_load", imemload, 32'h1224_FFEF);
        check("conflict_B_cnt", miss_cnt, 32'd3);
        next_cycle();
        imemaddr = 32'h0; mem_latency = 0;
        run_until_hit(20, fills);
        check("conflict_A_fills", fills, 32'd1);
        check("conflict_A_load", imemload, 32'h3C01_0001);
        check("conflict_A_cnt", miss_cnt, 32'd4);

        // Address change during a fill.
        next_cycle();
        imemaddr = 32'h10; mem_latency = 3;
        @(negedge CLK);
        check("midfill_miss_ihit", {31'd0, ihit}, 32'd0);
        next_cycle();
        imemaddr = 32'h20;
        @(negedge CLK);
        check("midfill_iaddr", iaddr, 32'h10);
        check("midfill_iREN", {31'd0, iREN}, 32'd1);
        n = 0;
        do begin
            next_cycle();
            @(negedge CLK);
            n++;
        end while (iREN && n < 20);
        check("midfill_end_iREN", {31'd0, iREN}, 32'd0);
        check("midfill_0x20_ihit", {31'd0, ihit}, 32'd0);
        check("midfill_cnt", miss_cnt, 32'd5);
        next_cycle();
        @(negedge CLK);
        check("refill_iaddr", iaddr, 32'h20);
        check("refill_cnt", miss_cnt, 32'd6);
        next_cycle();
        run_until_hit(20, fills);
        next_cycle();
        imemaddr = 32'h10;
        @(negedge CLK);
        check("retained_ihit", {31'd0, ihit}, 32'd1);
        check("retained_load", imemload, 32'h1230_FFFB);

        // Read enable low.
        next_cycle();
        imemREN = 1'b0;
        foreach (idle_addrs[i]) begin
            imemaddr = idle_addrs[i];
            @(negedge CLK);
            check("ren_low_ihit", {31'd0, ihit}, 32'd0);
            check("ren_low_load", imemload, 32'd0);
            check("ren_low_iREN", {31'd0, iREN}, 32'd0);
            check("ren_low_cnt", miss_cnt, 32'd6);
            next_cycle();
        end

        // Sweep of conflicting sets, high addresses and ignored byte bits.
        imemREN = 1'b1;
        foreach (sweep[i]) begin
            imemaddr = sweep[i].addr; mem_latency = sweep[i].lat;
            run_until_hit(20, fills);
            next_cycle();
        end
        @(negedge CLK);
        check("sweep_cnt", miss_cnt, 32'd11);

        // Reset in the middle of a fill.
        next_cycle();
        imemaddr = 32'h8; mem_latency = 5;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check("pre_abort_iREN", {31'd0, iREN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("abort_iREN", {31'd0, iREN}, 32'd0);
        check("abort_iaddr", iaddr, 32'd0);
        check("abort_ihit", {31'd0, ihit}, 32'd0);
        check("abort_cnt", miss_cnt, 32'd0);
        mem_latency = 0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        run_until_hit(20, fills);
        check("after_abort_fills", fills, 32'd1);
        check("after_abort_load", imemload, 32'h1236_FFFD);
        check("after_abort_cnt", miss_cnt, 32'd1);

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
